// File: rtl/fifo_ctrl_unit.sv
// fifo_ctrl_unit: pointer/flag controller that sequences a register file as a
// first-word-fall-through FIFO, with occupancy, level and sticky error flags.
module fifo_ctrl_unit #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clr_err,
  output logic             o_wr_en,
  output logic [WIDTH-1:0] o_w_ptr,
  output logic [WIDTH-1:0] o_r_ptr,
  output logic [WIDTH:0]   o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_overflow,
  output logic             o_underflow
);
  logic [WIDTH-1:0] r_w_ptr;
  logic [WIDTH-1:0] r_r_ptr;
  logic [WIDTH:0]   r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  assign w_full    = r_count == (WIDTH+1)'(DEPTH);
  assign w_empty   = r_count == '0;
  // A push into a full FIFO is fine when a pop frees the head slot this cycle.
  assign w_push_ok = i_push & (~w_full | i_pop);
  assign w_pop_ok  = i_pop & ~w_empty;
  assign o_wr_en       = w_push_ok;
  assign o_w_ptr       = r_w_ptr;
  assign o_r_ptr       = r_r_ptr;
  assign o_count       = r_count;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_almost_full = r_count >= (WIDTH+1)'(AF_LEVEL);
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_w_ptr     <= '0;
      r_r_ptr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_w_ptr <= r_w_ptr + 1'b1;
      if (w_pop_ok) r_r_ptr <= r_r_ptr + 1'b1;
      if (w_push_ok != w_pop_ok) r_count <= w_push_ok ? r_count + 1'b1 : r_count - 1'b1;
      r_overflow  <= ~i_clr_err & (r_overflow | (i_push & ~w_push_ok));
      r_underflow <= ~i_clr_err & (r_underflow | (i_pop & ~w_pop_ok));
    end
  end
endmodule

// File: tb/tb_fifo_ctrl_unit.sv
// tb_fifo_ctrl_unit: drives the controller with a behavioural storage array and
// compares against a queue-based FIFO model.
module tb_fifo_ctrl_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       clr_err = 1'b0;
  logic       wr_en;
  logic [3:0] w_ptr;
  logic [3:0] r_ptr;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       overflow;
  logic       underflow;
  logic [7:0] din = '0;
  logic [7:0] mem [16];
  int checks = 0;
  int failures = 0;
  logic [7:0] q [$];
  logic [3:0] wp = '0;
  logic [3:0] rp = '0;
  bit         eov = 0;
  bit         euf = 0;
  bit         obs_wr;
  bit         exp_wr;
  logic [7:0] obs_head;
  logic [7:0] exp_head;
  bit         had_head;

  fifo_ctrl_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_push(push), .i_pop(pop), .i_clr_err(clr_err),
    .o_wr_en(wr_en), .o_w_ptr(w_ptr), .o_r_ptr(r_ptr), .o_count(count),
    .o_full(full), .o_empty(empty), .o_almost_full(almost_full),
    .o_overflow(overflow), .o_underflow(underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (wr_en) mem[w_ptr] <= din;

  // One clock: drive inputs, capture pre-edge wr_en/head, then advance the model.
  task automatic cyc(input bit rn, input bit pu, input bit po, input bit cl, input logic [7:0] d);
    bit pok;
    bit wok;
    rst_n = rn; push = pu; pop = po; clr_err = cl; din = d;
    #2;
    obs_wr   = wr_en;
    obs_head = mem[r_ptr];
    had_head = q.size() > 0;
    exp_head = had_head ? q[0] : 8'h00;
    exp_wr   = pu && (q.size() < 16 || po);
    @(posedge clk);
    if (!rn) begin
      q.delete(); wp = 0; rp = 0; eov = 0; euf = 0;
    end else begin
      pok = po && q.size() > 0;
      wok = pu && (q.size() < 16 || po);
      if (pok) void'(q.pop_front());
      if (wok) q.push_back(d);
      wp = wp + 4'(wok);
      rp = rp + 4'(pok);
      eov = !cl && (eov || (pu && !wok));
      euf = !cl && (euf || (po && !pok));
    end
    #1;
  endtask

  task automatic test_reset;
    cyc(0, 1, 0, 0, 8'h11);
    cyc(0, 1, 0, 0, 8'h22);
    checks += 6;
    if (w_ptr !== 4'd0) begin failures++; $display("FAIL reset_w_ptr got=%0d exp=0", w_ptr); end
    if (r_ptr !== 4'd0) begin failures++; $display("FAIL reset_r_ptr got=%0d exp=0", r_ptr); end
    if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0)
      begin failures++; $display("FAIL reset_flags got e=%b f=%b af=%b exp e=1 f=0 af=0", empty, full, almost_full); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 0, 0, 8'(i));
      checks += 3;
      if (count !== 5'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
      if (almost_full !== (i + 1 >= 12)) begin failures++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, i + 1 >= 12); end
      if (full !== (i == 15)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 15); end
    end
    checks++;
    if (w_ptr !== 4'd0) begin failures++; $display("FAIL fill_wrap got=%0d exp=0", w_ptr); end
    cyc(1, 1, 0, 0, 8'hEE);
    checks += 3;
    if (obs_wr !== 1'b0) begin failures++; $display("FAIL fill_refused_wr got=%b exp=0", obs_wr); end
    if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
    if (count !== 5'd16) begin failures++; $display("FAIL fill_hold_count got=%0d exp=16", count); end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 1, 0, 8'h00);
      checks += 2;
      if (obs_head !== 8'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, obs_head, 8'(i)); end
      if (empty !== (i == 15)) begin failures++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, empty, i == 15); end
    end
    cyc(1, 0, 1, 0, 8'h00);
    checks += 2;
    if (underflow !== 1'b1) begin failures++; $display("FAIL drain_underflow got=%b exp=1", underflow); end
    if (r_ptr !== 4'd0) begin failures++; $display("FAIL drain_r_ptr got=%0d exp=0", r_ptr); end
    cyc(1, 0, 0, 1, 8'h00);
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0)
      begin failures++; $display("FAIL drain_clr got ov=%b uf=%b exp ov=0 uf=0", overflow, underflow); end
  endtask

  task automatic test_simultaneous;
    logic [3:0] w0;
    logic [3:0] r0;
    cyc(1, 1, 1, 0, 8'h30);
    checks += 3;
    if (obs_wr !== 1'b1) begin failures++; $display("FAIL sim_empty_wr got=%b exp=1", obs_wr); end
    if (count !== 5'd1) begin failures++; $display("FAIL sim_empty_count got=%0d exp=1", count); end
    if (underflow !== 1'b1) begin failures++; $display("FAIL sim_empty_uf got=%b exp=1", underflow); end
    cyc(1, 0, 0, 1, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 8'h31 + 8'(i));
    w0 = w_ptr; r0 = r_ptr;
    cyc(1, 1, 1, 0, 8'h40);
    checks += 4;
    if (count !== 5'd5) begin failures++; $display("FAIL sim_mid_count got=%0d exp=5", count); end
    if (w_ptr !== w0 + 4'd1) begin failures++; $display("FAIL sim_mid_w_ptr got=%0d exp=%0d", w_ptr, w0 + 4'd1); end
    if (r_ptr !== r0 + 4'd1) begin failures++; $display("FAIL sim_mid_r_ptr got=%0d exp=%0d", r_ptr, r0 + 4'd1); end
    if (obs_head !== 8'h30) begin failures++; $display("FAIL sim_mid_head got=%h exp=30", obs_head); end
    for (int i = 0; i < 11; i++) cyc(1, 1, 0, 0, 8'h50 + 8'(i));
    cyc(1, 1, 1, 0, 8'hC3);
    checks += 5;
    if (obs_wr !== 1'b1) begin failures++; $display("FAIL sim_full_wr got=%b exp=1", obs_wr); end
    if (obs_head !== 8'h31) begin failures++; $display("FAIL sim_full_head got=%h exp=31", obs_head); end
    if (count !== 5'd16 || full !== 1'b1) begin failures++; $display("FAIL sim_full_count got=%0d f=%b exp=16 f=1", count, full); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL sim_full_ov got=%b exp=0", overflow); end
    if (w_ptr !== r_ptr) begin failures++; $display("FAIL sim_full_ptrs got w=%0d r=%0d exp equal", w_ptr, r_ptr); end
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 1, 0, 8'h00);
      checks++;
      if (obs_head !== exp_head) begin failures++; $display("FAIL sim_drain[%0d] got=%h exp=%h", i, obs_head, exp_head); end
    end
    checks++;
    if (exp_head !== 8'hC3 || empty !== 1'b1) begin failures++; $display("FAIL sim_drain_last got=%h e=%b exp=c3 e=1", exp_head, empty); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, 8'h60 + 8'(i));
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 8'h00);
    cyc(0, 1, 1, 0, 8'h77);
    checks += 4;
    if (count !== 5'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", count); end
    if (w_ptr !== 4'd0 || r_ptr !== 4'd0) begin failures++; $display("FAIL rmid_ptrs got w=%0d r=%0d exp 0 0", w_ptr, r_ptr); end
    if (empty !== 1'b1) begin failures++; $display("FAIL rmid_empty got=%b exp=1", empty); end
    cyc(1, 1, 0, 0, 8'hA5);
    cyc(1, 0, 1, 0, 8'h00);
    if (obs_head !== 8'hA5) begin failures++; $display("FAIL rmid_data got=%h exp=a5", obs_head); end
  endtask

  task automatic test_random;
    int pp;
    bit rn;
    bit pu;
    bit po;
    bit cl;
    for (int c = 0; c < 10000; c++) begin
      pp = ((c / 400) % 3 == 0) ? 75 : ((c / 400) % 3 == 1) ? 25 : 50;
      rn = $urandom_range(0, 299) != 0;
      pu = $urandom_range(0, 99) < pp;
      po = $urandom_range(0, 99) < 100 - pp;
      cl = $urandom_range(0, 15) == 0;
      cyc(rn, pu, po, cl, 8'($urandom));
      checks += 6;
      if (rn && obs_wr !== exp_wr) begin failures++; $display("FAIL rnd_wr[%0d] got=%b exp=%b", c, obs_wr, exp_wr); end
      if (rn && had_head && obs_head !== exp_head) begin failures++; $display("FAIL rnd_data[%0d] got=%h exp=%h", c, obs_head, exp_head); end
      if (count !== 5'(q.size())) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", c, count, q.size()); end
      if (full !== (q.size() == 16) || empty !== (q.size() == 0) || almost_full !== (q.size() >= 12))
        begin failures++; $display("FAIL rnd_flags[%0d] got f=%b e=%b af=%b size=%0d", c, full, empty, almost_full, q.size()); end
      if (overflow !== eov || underflow !== euf)
        begin failures++; $display("FAIL rnd_err[%0d] got ov=%b uf=%b exp ov=%b uf=%b", c, overflow, underflow, eov, euf); end
      if (w_ptr !== wp || r_ptr !== rp)
        begin failures++; $display("FAIL rnd_ptrs[%0d] got w=%0d r=%0d exp w=%0d r=%0d", c, w_ptr, r_ptr, wp, rp); end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_fill;
    test_drain;
    test_simultaneous;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
